// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PAR,
        STOP,
        ACK_REL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus clock falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall
);

    logic clk_q1;
    logic dat_q1;
    logic clk_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q1   <= 1'b1;
            clk_s    <= 1'b1;
            dat_q1   <= 1'b1;
            dat_s    <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            clk_q1   <= ps2_clk;
            clk_s    <= clk_q1;
            dat_q1   <= ps2_dat;
            dat_s    <= dat_q1;
            clk_prev <= clk_s;
        end
    end

    assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then device acknowledge, with a per-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_END  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_s;
    logic dat_s;
    logic fall;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       sh, sh_d;
    logic             par, par_d;
    logic [3:0]       bitcnt, bitcnt_d;
    logic [1:0]       code_d;
    logic             clk_oe_d, dat_oe_d, done_d, error_d;
    logic             watched;
    logic             ack_release;
    logic             tmo;

    ps2_line_sync u_sync (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .ps2_clk  (ps2_clk_in),
        .ps2_dat  (ps2_dat_in),
        .clk_s    (clk_s),
        .dat_s    (dat_s),
        .clk_fall (fall)
    );

    assign watched     = (state == REQ) || (state == DATA) || (state == PAR) ||
                         (state == STOP) || (state == ACK_REL);
    assign ack_release = (state == ACK_REL) && clk_s && dat_s;
    // A fall on the terminal-count cycle still wins, and a completed ack beats the watchdog.
    assign tmo         = watched && !fall && !ack_release && (cnt == TMO_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            bitcnt     <= '0;
            err_code   <= ERR_NONE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sh         <= sh_d;
            par        <= par_d;
            bitcnt     <= bitcnt_d;
            err_code   <= code_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sh_d     = sh;
        par_d    = par;
        bitcnt_d = bitcnt;
        code_d   = err_code;
        if (watched) begin
            cnt_d = fall ? '0 : cnt + CNT_W'(1);
        end
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    sh_d     = tx_data;
                    par_d    = odd_parity(tx_data);
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    code_d   = ERR_NONE;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_END) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            REQ: begin
                if (fall) begin
                    sh_d     = sh >> 1;
                    bitcnt_d = 4'd1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                // bitcnt counts data bits already on the line; after eight, parity goes out.
                if (fall) begin
                    if (bitcnt == 4'd8) begin
                        state_d = PAR;
                    end else begin
                        sh_d     = sh >> 1;
                        bitcnt_d = bitcnt + 4'd1;
                    end
                end
            end
            PAR: begin
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (fall) begin
                    if (dat_s) begin
                        code_d  = ERR_NOACK;
                        state_d = IDLE;
                    end else begin
                        state_d = ACK_REL;
                    end
                end
            end
            ACK_REL: begin
                if (ack_release) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            code_d  = ERR_TIMEOUT;
            state_d = IDLE;
        end
    end

    always_comb begin
        clk_oe_d = 1'b0;
        dat_oe_d = ps2_dat_oe;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_d = tx_valid;
                dat_oe_d = 1'b0;
            end
            INHIBIT: begin
                // Start bit overlaps the final inhibit cycle so data is low before clock releases.
                clk_oe_d = (cnt != INH_END);
                dat_oe_d = (cnt >= INH_LAST);
            end
            REQ: begin
                dat_oe_d = fall ? ~sh[0] : 1'b1;
            end
            DATA: begin
                if (fall) dat_oe_d = (bitcnt == 4'd8) ? ~par : ~sh[0];
            end
            PAR: begin
                if (fall) dat_oe_d = 1'b0;
            end
            STOP: begin
                dat_oe_d = 1'b0;
                error_d  = fall & dat_s;
            end
            ACK_REL: begin
                dat_oe_d = 1'b0;
                done_d   = ack_release;
            end
            default: dat_oe_d = 1'b0;
        endcase
        if (tmo) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
